// File: rtl/pong_motion_ctrl.sv
// pong_motion_ctrl: per-frame paddle, ball, score and serve sequencer for the Pong display
module pong_motion_ctrl #(
    parameter int PADDLE_W     = 10,
    parameter int PADDLE_H     = 120,
    parameter int P1_X         = 20,
    parameter int P2_X         = 610,
    parameter int BALL_SIZE    = 8,
    parameter int BORDER       = 2,
    parameter int PADDLE_STEP  = 4,
    parameter int BALL_STEP    = 2,
    parameter int SERVE_FRAMES = 60,
    parameter int SCORE_MAX    = 9
) (
    input  logic       pixel_clk,
    input  logic       reset,
    input  logic       V_visible,
    input  logic       P1_up,
    input  logic       P1_down,
    input  logic       P2_up,
    input  logic       P2_down,
    input  logic       start_btn,
    output logic [9:0] P1_paddle_y,
    output logic [9:0] P2_paddle_y,
    output logic [9:0] ball_x,
    output logic [9:0] ball_y,
    output logic [3:0] P1_score,
    output logic [3:0] P2_score,
    output logic       game_over
);
    localparam logic [1:0] ST_SERVE = 2'd0;
    localparam logic [1:0] ST_PLAY  = 2'd1;
    localparam logic [1:0] ST_OVER  = 2'd2;
    localparam int CW = $clog2(SERVE_FRAMES + 1);
    localparam logic [CW-1:0] CNT_INIT = CW'(SERVE_FRAMES);
    localparam logic [9:0]  CX        = 10'((640 - BALL_SIZE) / 2);
    localparam logic [9:0]  CY        = 10'((480 - BALL_SIZE) / 2);
    localparam logic [9:0]  P_INIT    = 10'((480 - PADDLE_H) / 2);
    localparam logic [10:0] P_MIN     = 11'(BORDER);
    localparam logic [10:0] P_MAX     = 11'(480 - BORDER - PADDLE_H);
    localparam logic [10:0] P_STEP    = 11'(PADDLE_STEP);
    localparam logic [9:0]  STEP      = 10'(BALL_STEP);
    localparam logic [9:0]  Y_TOP     = 10'(BORDER);
    localparam logic [9:0]  Y_BOT     = 10'(480 - BORDER - BALL_SIZE);
    localparam logic [9:0]  Y_UP_LIM  = 10'(BORDER + BALL_STEP);
    localparam logic [9:0]  Y_DN_LIM  = 10'(480 - BORDER - BALL_SIZE - BALL_STEP);
    localparam logic [9:0]  X_L_PLANE = 10'(P1_X + PADDLE_W);
    localparam logic [9:0]  X_L_HIT   = 10'(P1_X + PADDLE_W + BALL_STEP);
    localparam logic [9:0]  X_R_PLANE = 10'(P2_X - BALL_SIZE);
    localparam logic [9:0]  X_R_HIT   = 10'(P2_X - BALL_SIZE - BALL_STEP);
    localparam logic [9:0]  X_L_WALL  = 10'(BORDER + BALL_STEP);
    localparam logic [9:0]  X_R_WALL  = 10'(640 - BORDER - BALL_SIZE - BALL_STEP);
    localparam logic [10:0] SZ        = 11'(BALL_SIZE);
    localparam logic [10:0] PH        = 11'(PADDLE_H);
    localparam logic [3:0]  S_MAX     = 4'(SCORE_MAX);

    logic [4:0] sync1_q, sync2_q;
    logic v_q, tick;
    logic [1:0] state_q, state_d;
    logic [CW-1:0] cnt_q, cnt_d;
    logic [9:0] p1_q, p1_d, p2_q, p2_d, bx_q, bx_d, by_q, by_d;
    logic dx_q, dx_d, dy_q, dy_d;
    logic [3:0] s1_q, s1_d, s2_q, s2_d;
    logic p1_pt, p2_pt, ov1, ov2;

    // Paddle step in 11 bits so moving up near the border cannot wrap before the clamp.
    function automatic logic [9:0] paddle_next(input logic [9:0] y, input logic up, input logic dn);
        logic [10:0] w;
        w = {1'b0, y};
        if (up && !dn)
            w = (w < P_MIN + P_STEP) ? P_MIN : w - P_STEP;
        else if (dn && !up)
            w = (w + P_STEP > P_MAX) ? P_MAX : w + P_STEP;
        return w[9:0];
    endfunction

    assign tick = v_q & ~V_visible;
    assign ov1 = ({1'b0, by_q} + SZ > {1'b0, p1_q}) && ({1'b0, by_q} < {1'b0, p1_q} + PH);
    assign ov2 = ({1'b0, by_q} + SZ > {1'b0, p2_q}) && ({1'b0, by_q} < {1'b0, p2_q} + PH);

    // Button synchronisers and the vertical-visible delay that defines the frame tick.
    always_ff @(posedge pixel_clk or posedge reset) begin
        if (reset) begin
            sync1_q <= '0;
            sync2_q <= '0;
            v_q     <= 1'b0;
        end else begin
            sync1_q <= {start_btn, P2_down, P2_up, P1_down, P1_up};
            sync2_q <= sync1_q;
            v_q     <= V_visible;
        end
    end

    // Per-tick game step: paddles, serve countdown, ball motion, scoring and restart.
    always_comb begin
        state_d = state_q;
        cnt_d   = cnt_q;
        p1_d    = p1_q;
        p2_d    = p2_q;
        bx_d    = bx_q;
        by_d    = by_q;
        dx_d    = dx_q;
        dy_d    = dy_q;
        s1_d    = s1_q;
        s2_d    = s2_q;
        p1_pt   = 1'b0;
        p2_pt   = 1'b0;
        if (tick && state_q != ST_OVER) begin
            p1_d = paddle_next(p1_q, sync2_q[0], sync2_q[1]);
            p2_d = paddle_next(p2_q, sync2_q[2], sync2_q[3]);
        end
        if (tick && state_q == ST_SERVE) begin
            cnt_d = cnt_q - CW'(1);
            if (cnt_q == CW'(1)) state_d = ST_PLAY;
        end
        if (tick && state_q == ST_PLAY) begin
            if (dy_q) begin
                by_d = (by_q >= Y_DN_LIM) ? Y_BOT : by_q + STEP;
                dy_d = by_q < Y_DN_LIM;
            end else begin
                by_d = (by_q <= Y_UP_LIM) ? Y_TOP : by_q - STEP;
                dy_d = by_q <= Y_UP_LIM;
            end
            if (dx_q) begin
                if (bx_q >= X_R_HIT && bx_q <= X_R_PLANE && ov2) begin
                    bx_d = X_R_PLANE;
                    dx_d = 1'b0;
                end else if (bx_q >= X_R_WALL) p1_pt = 1'b1;
                else bx_d = bx_q + STEP;
            end else begin
                if (bx_q <= X_L_HIT && bx_q >= X_L_PLANE && ov1) begin
                    bx_d = X_L_PLANE;
                    dx_d = 1'b1;
                end else if (bx_q <= X_L_WALL) p2_pt = 1'b1;
                else bx_d = bx_q - STEP;
            end
            if (p1_pt || p2_pt) begin
                bx_d    = CX;
                by_d    = CY;
                dx_d    = p1_pt;
                dy_d    = dy_q;
                s1_d    = s1_q + {3'b0, p1_pt && s1_q != S_MAX};
                s2_d    = s2_q + {3'b0, p2_pt && s2_q != S_MAX};
                state_d = (s1_d == S_MAX || s2_d == S_MAX) ? ST_OVER : ST_SERVE;
                cnt_d   = CNT_INIT;
            end
        end
        if (tick && state_q == ST_OVER && sync2_q[4]) begin
            s1_d    = '0;
            s2_d    = '0;
            bx_d    = CX;
            by_d    = CY;
            cnt_d   = CNT_INIT;
            state_d = ST_SERVE;
        end
    end

    // Game state registers; async reset returns to a fresh serve.
    always_ff @(posedge pixel_clk or posedge reset) begin
        if (reset) begin
            state_q <= ST_SERVE;
            cnt_q   <= CNT_INIT;
            p1_q    <= P_INIT;
            p2_q    <= P_INIT;
            bx_q    <= CX;
            by_q    <= CY;
            dx_q    <= 1'b1;
            dy_q    <= 1'b1;
            s1_q    <= '0;
            s2_q    <= '0;
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
            p1_q    <= p1_d;
            p2_q    <= p2_d;
            bx_q    <= bx_d;
            by_q    <= by_d;
            dx_q    <= dx_d;
            dy_q    <= dy_d;
            s1_q    <= s1_d;
            s2_q    <= s2_d;
        end
    end

    assign P1_paddle_y = p1_q;
    assign P2_paddle_y = p2_q;
    assign ball_x      = bx_q;
    assign ball_y      = by_q;
    assign P1_score    = s1_q;
    assign P2_score    = s2_q;
    assign game_over   = state_q == ST_OVER;
endmodule

// File: tb/tb_pong_motion_ctrl.sv
// tb_pong_motion_ctrl: frame-level reference model check of the Pong sequencer
module tb_pong_motion_ctrl;
    logic pixel_clk, reset, V_visible;
    logic P1_up, P1_down, P2_up, P2_down, start_btn;
    logic [9:0] P1_paddle_y, P2_paddle_y, ball_x, ball_y;
    logic [3:0] P1_score, P2_score;
    logic game_over;

    int errors = 0;
    int checks = 0;
    int m_p1, m_p2, m_bx, m_by, m_dx, m_dy, m_s1, m_s2, m_st, m_cnt;

    pong_motion_ctrl dut (
        .pixel_clk(pixel_clk), .reset(reset), .V_visible(V_visible),
        .P1_up(P1_up), .P1_down(P1_down), .P2_up(P2_up), .P2_down(P2_down),
        .start_btn(start_btn),
        .P1_paddle_y(P1_paddle_y), .P2_paddle_y(P2_paddle_y),
        .ball_x(ball_x), .ball_y(ball_y),
        .P1_score(P1_score), .P2_score(P2_score), .game_over(game_over)
    );

    initial pixel_clk = 1'b0;
    always #5 pixel_clk = ~pixel_clk;

    task automatic chk(input string tag, input int obs, input int exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s observed=%0d expected=%0d", tag, obs, exp);
        end
    endtask

    task automatic check_all(input string w);
        chk({w, "/p1_y"}, int'(P1_paddle_y), m_p1);
        chk({w, "/p2_y"}, int'(P2_paddle_y), m_p2);
        chk({w, "/ball_x"}, int'(ball_x), m_bx);
        chk({w, "/ball_y"}, int'(ball_y), m_by);
        chk({w, "/p1_score"}, int'(P1_score), m_s1);
        chk({w, "/p2_score"}, int'(P2_score), m_s2);
        chk({w, "/game_over"}, int'(game_over), int'(m_st == 2));
    endtask

    function automatic int clamp(input int v, input int lo, input int hi);
        return v < lo ? lo : (v > hi ? hi : v);
    endfunction

    task automatic model_reset();
        m_p1 = 180; m_p2 = 180; m_bx = 316; m_by = 236;
        m_dx = 1; m_dy = 1; m_s1 = 0; m_s2 = 0; m_st = 0; m_cnt = 60;
    endtask

    // One frame of the game, written from the rules: state 0 serve, 1 play, 2 game over.
    task automatic model_tick(input int u1, input int d1, input int u2, input int d2, input int st);
        int nx, ny, ndx, ndy, win;
        bit hit1, hit2;
        if (m_st == 2) begin
            if (st != 0) begin
                m_s1 = 0; m_s2 = 0; m_bx = 316; m_by = 236; m_cnt = 60; m_st = 0;
            end
        end else begin
            if (m_st == 0) begin
                m_cnt--;
                if (m_cnt == 0) m_st = 1;
            end else begin
                nx = m_bx + 2 * m_dx; ny = m_by + 2 * m_dy; ndx = m_dx; ndy = m_dy; win = 0;
                if (m_dy < 0 && m_by <= 4) begin ny = 2; ndy = 1; end
                else if (m_dy > 0 && m_by + 10 >= 478) begin ny = 470; ndy = -1; end
                hit1 = (m_by + 8 > m_p1) && (m_by < m_p1 + 120);
                hit2 = (m_by + 8 > m_p2) && (m_by < m_p2 + 120);
                if (m_dx < 0) begin
                    if (nx <= 30 && m_bx >= 30 && hit1) begin nx = 30; ndx = 1; end
                    else if (nx <= 2) win = 2;
                end else begin
                    if (nx >= 602 && m_bx <= 602 && hit2) begin nx = 602; ndx = -1; end
                    else if (nx + 8 >= 638) win = 1;
                end
                if (win != 0) begin
                    if (win == 1) m_s1 = (m_s1 < 9) ? m_s1 + 1 : 9;
                    else m_s2 = (m_s2 < 9) ? m_s2 + 1 : 9;
                    m_bx = 316; m_by = 236; m_dx = (win == 1) ? 1 : -1;
                    m_st = (m_s1 == 9 || m_s2 == 9) ? 2 : 0;
                    m_cnt = 60;
                end else begin
                    m_bx = nx; m_by = ny; m_dx = ndx; m_dy = ndy;
                end
            end
            m_p1 = clamp(m_p1 + 4 * (d1 - u1), 2, 358);
            m_p2 = clamp(m_p2 + 4 * (d2 - u2), 2, 358);
        end
    endtask

    // Visible for 4 cycles (outputs must hold), then blank; the tick lands on the first blank edge.
    task automatic frame(input bit u1, input bit d1, input bit u2, input bit d2, input bit st);
        @(negedge pixel_clk);
        P1_up = u1; P1_down = d1; P2_up = u2; P2_down = d2; start_btn = st;
        V_visible = 1'b1;
        repeat (4) @(negedge pixel_clk);
        check_all("hold");
        V_visible = 1'b0;
        @(negedge pixel_clk);
        model_tick(int'(u1), int'(d1), int'(u2), int'(d2), int'(st));
        check_all("tick");
        repeat (2) @(negedge pixel_clk);
    endtask

    task automatic rand_frame();
        frame(1'($urandom), 1'($urandom), 1'($urandom), 1'($urandom), 1'b0);
    endtask

    // P1 follows the ball while P2 runs to the far side, so P1 eventually wins.
    task automatic steer_frame();
        int c, t2;
        c = m_by - 56;
        t2 = (m_by < 236) ? 358 : 2;
        frame(m_p1 > c + 3, m_p1 + 3 < c, m_p2 > t2, m_p2 < t2, 1'b0);
    endtask

    initial begin
        int n;
        reset = 1'b1; V_visible = 1'b0;
        P1_up = 0; P1_down = 0; P2_up = 0; P2_down = 0; start_btn = 0;
        model_reset();
        repeat (3) @(negedge pixel_clk);
        check_all("reset");
        reset = 1'b0;
        repeat (3) frame(0, 0, 0, 0, 0);
        chk("idle_p1", int'(P1_paddle_y), 180);
        chk("idle_ball_x", int'(ball_x), 316);
        repeat (2) frame(1, 1, 0, 0, 0);
        chk("both_hold", int'(P1_paddle_y), 180);
        frame(1, 0, 0, 0, 0);
        chk("up_first", int'(P1_paddle_y), 176);
        repeat (49) frame(1, 0, 0, 0, 0);
        chk("up_clamp", int'(P1_paddle_y), 2);
        repeat (5) frame(0, 0, 0, 0, 0);
        chk("serve_t60_x", int'(ball_x), 316);
        chk("serve_t60_y", int'(ball_y), 236);
        frame(0, 0, 0, 0, 0);
        chk("serve_t61_x", int'(ball_x), 318);
        chk("serve_t61_y", int'(ball_y), 238);
        repeat (400) rand_frame();
        n = 0;
        while (m_st != 2 && n < 6000) begin
            steer_frame();
            n++;
        end
        chk("game_over_reached", int'(game_over), 1);
        repeat (3) frame(1'($urandom), 1'($urandom), 1'($urandom), 1'($urandom), 1'b0);
        chk("over_frozen", int'(game_over), 1);
        frame(0, 0, 0, 0, 1);
        chk("restart_p1_score", int'(P1_score), 0);
        chk("restart_over", int'(game_over), 0);
        repeat (70) rand_frame();
        @(negedge pixel_clk);
        V_visible = 1'b1;
        #2 reset = 1'b1;
        #1;
        chk("async_p1", int'(P1_paddle_y), 180);
        chk("async_p2", int'(P2_paddle_y), 180);
        chk("async_bx", int'(ball_x), 316);
        chk("async_by", int'(ball_y), 236);
        chk("async_s1", int'(P1_score), 0);
        chk("async_s2", int'(P2_score), 0);
        chk("async_over", int'(game_over), 0);
        @(negedge pixel_clk);
        reset = 1'b0;
        model_reset();
        repeat (3) rand_frame();
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end
endmodule
